// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// Requester 0 is the core datapath, requester 1 an auxiliary unit. A grant
// latches the request's control code and operands, drives the ALU for one
// cycle, captures result and zero flag, and returns them with a done pulse.
// Ties are broken round-robin on the last granted requester.
module alu_share_arb #(
  parameter int                 DATA_W       = 32,
  parameter int                 CTRL_W       = 4,
  parameter logic [CTRL_W-1:0]  ILLEGAL_CTRL = 4'b1111
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [CTRL_W-1:0] ctrl0_i,
  input  logic [DATA_W-1:0] src1_0_i,
  input  logic [DATA_W-1:0] src2_0_i,
  input  logic              req1_i,
  input  logic [CTRL_W-1:0] ctrl1_i,
  input  logic [DATA_W-1:0] src1_1_i,
  input  logic [DATA_W-1:0] src2_1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rslt_o,
  output logic              zero_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  input  logic [DATA_W-1:0] alu_rslt_i,
  input  logic              alu_zero_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic                last_gnt;   // requester granted most recently
  logic                owner;      // requester that owns the operation in flight
  logic [CTRL_W-1:0]   op_ctrl;
  logic [DATA_W-1:0]   op_src1;
  logic [DATA_W-1:0]   op_src2;
  logic [DATA_W-1:0]   rslt_cap;   // ALU result captured at the end of EXEC
  logic                zero_cap;
  logic                err_pend;   // granted request carried ILLEGAL_CTRL

  logic                grant0;
  logic                grant1;
  logic [CTRL_W-1:0]   sel_ctrl;
  logic [DATA_W-1:0]   sel_src1;
  logic [DATA_W-1:0]   sel_src2;

  // Arbitration: a lone request wins; on a tie the requester not granted last wins.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    grant0   = 1'b0;
    grant1   = 1'b0;
    sel_ctrl = ctrl0_i;
    sel_src1 = src1_0_i;
    sel_src2 = src2_0_i;
    if (req0_i && (!req1_i || last_gnt)) begin
      grant0 = 1'b1;
    end else if (req1_i) begin
      grant1   = 1'b1;
      sel_ctrl = ctrl1_i;
      sel_src1 = src1_1_i;
      sel_src2 = src2_1_i;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state    <= IDLE;
      last_gnt <= 1'b1;
      owner    <= 1'b0;
      op_ctrl  <= '0;
      op_src1  <= '0;
      op_src2  <= '0;
      rslt_cap <= '0;
      zero_cap <= 1'b0;
      err_pend <= 1'b0;
      ack0_o   <= 1'b0;
      ack1_o   <= 1'b0;
      done0_o  <= 1'b0;
      done1_o  <= 1'b0;
      rslt_o   <= '0;
      zero_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      ack0_o  <= 1'b0;
      ack1_o  <= 1'b0;
      done0_o <= 1'b0;
      done1_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_ctrl  <= sel_ctrl;
            op_src1  <= sel_src1;
            op_src2  <= sel_src2;
            owner    <= grant1;
            last_gnt <= grant1;
            ack0_o   <= grant0;
            ack1_o   <= grant1;
            if (sel_ctrl == ILLEGAL_CTRL) begin
              // Rejected without using the ALU: respond next cycle with an error.
              rslt_cap <= '0;
              zero_cap <= 1'b0;
              err_pend <= 1'b1;
              state    <= RESP;
            end else begin
              err_pend <= 1'b0;
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          rslt_cap <= alu_rslt_i;
          zero_cap <= alu_zero_i;
          state    <= RESP;
        end
        RESP: begin
          done0_o <= ~owner;
          done1_o <= owner;
          rslt_o  <= rslt_cap;
          zero_o  <= zero_cap;
          err_o   <= err_pend;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The ALU always sees the operand registers, so its inputs never go X.
  assign alu_ctrl_o = op_ctrl;
  assign alu_src1_o = op_src1;
  assign alu_src2_o = op_src2;
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: randomized and directed traffic from two requesters; a
// monitor predicts grant order and results at each ack and checks the done
// responses from a scoreboard queue. The ALU itself is modelled in the bench.
module tb_alu_share_arb;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] ILL = 4'b1111;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req0_i = 1'b0, req1_i = 1'b0;
  logic [CW-1:0] ctrl0_i = '0, ctrl1_i = '0;
  logic [DW-1:0] src1_0_i = '0, src2_0_i = '0, src1_1_i = '0, src2_1_i = '0;
  logic          ack0_o, ack1_o, done0_o, done1_o, zero_o, err_o, busy_o;
  logic [DW-1:0] rslt_o, alu_src1_o, alu_src2_o;
  logic [CW-1:0] alu_ctrl_o;
  logic [DW-1:0] alu_rslt_i;
  logic          alu_zero_i;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  alu_share_arb #(.DATA_W(DW), .CTRL_W(CW), .ILLEGAL_CTRL(ILL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .ctrl0_i(ctrl0_i), .src1_0_i(src1_0_i), .src2_0_i(src2_0_i),
    .req1_i(req1_i), .ctrl1_i(ctrl1_i), .src1_1_i(src1_1_i), .src2_1_i(src2_1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .done0_o(done0_o), .done1_o(done1_o),
    .rslt_o(rslt_o), .zero_o(zero_o), .err_o(err_o), .busy_o(busy_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_rslt_i(alu_rslt_i), .alu_zero_i(alu_zero_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference ALU: used both to drive the DUT's ALU port and to predict results.
  function automatic logic [DW-1:0] alu_ref(input logic [CW-1:0] c,
                                            input logic [DW-1:0] a, b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    alu_rslt_i = alu_ref(alu_ctrl_o, alu_src1_o, alu_src2_o);
    alu_zero_i = (alu_rslt_i == '0);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit            owner;
    logic [DW-1:0] rslt;
    bit            zero;
    bit            err;
    int            due;
  } exp_t;

  exp_t sb[$];

  // Monitor state: inputs as they will be seen at the next rising edge.
  logic          p_req0 = 1'b0, p_req1 = 1'b0;
  logic [CW-1:0] p_ctrl0 = '0, p_ctrl1 = '0;
  logic [DW-1:0] p_a0 = '0, p_b0 = '0, p_a1 = '0, p_b1 = '0;
  bit            model_last = 1'b1;
  bit            expect_zero = 1'b0;

  always @(negedge clk_i) begin
    exp_t          e;
    int            exp_own;
    logic [CW-1:0] c;
    logic [DW-1:0] a, b;
    cycle++;
    if (expect_zero) begin
      check("reset_handshake", {28'd0, ack0_o, ack1_o, done0_o, done1_o}, 32'd0);
      check("reset_flags", {29'd0, zero_o, err_o, busy_o}, 32'd0);
      check("reset_rslt", rslt_o, 32'd0);
      check("reset_alu_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
      check("reset_alu_src1", alu_src1_o, 32'd0);
      check("reset_alu_src2", alu_src2_o, 32'd0);
      expect_zero = 1'b0;
    end
    if (ack0_o || ack1_o) begin
      check("ack_exclusive", {31'd0, ack0_o & ack1_o}, 32'd0);
      if (p_req0 && p_req1) exp_own = model_last ? 0 : 1;
      else if (p_req0)      exp_own = 0;
      else if (p_req1)      exp_own = 1;
      else                  exp_own = 2;
      check("grant_owner", ack1_o ? 32'd1 : 32'd0, exp_own);
      model_last = ack1_o;
      c = ack1_o ? p_ctrl1 : p_ctrl0;
      a = ack1_o ? p_a1 : p_a0;
      b = ack1_o ? p_b1 : p_b0;
      check("alu_ctrl_drive", {28'd0, alu_ctrl_o}, {28'd0, c});
      check("alu_src1_drive", alu_src1_o, a);
      check("alu_src2_drive", alu_src2_o, b);
      check("busy_after_ack", {31'd0, busy_o}, 32'd1);
      e.owner = ack1_o;
      e.err   = (c == ILL);
      e.rslt  = e.err ? '0 : alu_ref(c, a, b);
      e.zero  = (e.rslt == '0);
      e.due   = cycle + (e.err ? 1 : 2);
      sb.push_back(e);
    end
    if (done0_o || done1_o) begin
      check("done_exclusive", {31'd0, done0_o & done1_o}, 32'd0);
      if (sb.size() == 0) begin
        check("done_unexpected", {31'd0, done1_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("done_owner", {31'd0, done1_o}, {31'd0, e.owner});
        check("done_latency", cycle, e.due);
        check("done_err", {31'd0, err_o}, {31'd0, e.err});
        check("done_rslt", rslt_o, e.rslt);
        if (!e.err) check("done_zero", {31'd0, zero_o}, {31'd0, e.zero});
      end
    end
    if (!rst_i) begin
      sb.delete();
      model_last  = 1'b1;
      expect_zero = 1'b1;
    end
    p_req0 = req0_i;  p_req1 = req1_i;
    p_ctrl0 = ctrl0_i; p_ctrl1 = ctrl1_i;
    p_a0 = src1_0_i;  p_b0 = src2_0_i;
    p_a1 = src1_1_i;  p_b1 = src2_1_i;
  end

  // Present one request from requester k and hold it until acked. Afterwards
  // the operands are scrambled; req stays high only if hold is set.
  task automatic issue(input int k, input logic [CW-1:0] c,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold);
    int  n;
    bit  acked;
    if (k == 0) begin req0_i = 1'b1; ctrl0_i = c; src1_0_i = a; src2_0_i = b; end
    else        begin req1_i = 1'b1; ctrl1_i = c; src1_1_i = a; src2_1_i = b; end
    acked = 1'b0;
    n = 0;
    while (!acked && n < 50) begin
      @(posedge clk_i); #1;
      acked = (k == 0) ? ack0_o : ack1_o;
      n++;
    end
    if (!acked) check("ack_timeout", k, 32'hFFFF_FFFF);
    if (k == 0) begin
      req0_i = hold; src1_0_i = $urandom; src2_0_i = $urandom; ctrl0_i = 4'($urandom);
    end else begin
      req1_i = hold; src1_1_i = $urandom; src2_1_i = $urandom; ctrl1_i = 4'($urandom);
    end
  endtask

  function automatic logic [CW-1:0] rand_ctrl();
    logic [CW-1:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};
    return ops[$urandom_range(7)];
  endfunction

  task automatic random_traffic(input int k, input int nops);
    logic [DW-1:0] a, b;
    bit            hold;
    for (int i = 0; i < nops; i++) begin
      a = $urandom;
      b = ($urandom_range(3) == 0) ? a : $urandom;
      hold = (i < nops - 1) && ($urandom_range(1) == 1);
      issue(k, rand_ctrl(), a, b, hold);
      if (!hold) repeat ($urandom_range(3)) @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Basic ADD from requester 0, then SUB of equal operands from requester 1.
    issue(0, 4'b0010, 32'd5, 32'd7, 1'b0);
    wait_idle();
    issue(1, 4'b0110, 32'h1234, 32'h1234, 1'b0);
    wait_idle();

    // Both held continuously for four operations: grants alternate.
    fork
      begin issue(0, 4'b0010, 32'd100, 32'd1, 1'b1); issue(0, 4'b0001, 32'hF0, 32'h0F, 1'b0); end
      begin issue(1, 4'b0000, 32'hFF, 32'h3C, 1'b1); issue(1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0); end
    join
    wait_idle();

    // Illegal control code.
    issue(0, ILL, 32'd9, 32'd9, 1'b0);
    wait_idle();

    // Reset during EXEC of a requester 1 operation.
    req1_i = 1'b1; ctrl1_i = 4'b0010; src1_1_i = 32'd3; src2_1_i = 32'd4;
    n = 0;
    do begin @(posedge clk_i); #1; n++; end while (!ack1_o && n < 50);
    if (!ack1_o) check("ack_timeout_rst", 32'd1, 32'hFFFF_FFFF);
    rst_i = 1'b0; req1_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    fork
      issue(0, 4'b0110, 32'd50, 32'd8, 1'b0);
      issue(1, 4'b0010, 32'd1, 32'd2, 1'b0);
    join
    wait_idle();

    // Requester 0 held high across two operations with operands changed after ack.
    issue(0, 4'b0010, 32'd10, 32'd20, 1'b1);
    issue(0, 4'b0110, 32'd7, 32'd7, 1'b0);
    wait_idle();

    // Randomized concurrent traffic.
    fork
      random_traffic(0, 30);
      random_traffic(1, 30);
    join
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbitrates one shared combinational ALU between two requesters: req 0 is the core datapath, req 1 is an auxiliary unit such as a branch-compare or address helper.
- Each request carries a 4-bit ALU control code and two 32-bit operands. The block registers them, drives the ALU, captures the result and zero flag, and returns them with a done pulse.
- Sits between the ALU controller outputs and the ALU inputs.

Parameters:
- DATA_W, 32, operand/result width.
- CTRL_W, 4, ALU control code width.
- ILLEGAL_CTRL, 4'b1111, control code that is rejected without using the ALU.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous and active-low.
- req0_i  in  1  requester 0 request; hold until ack0_o.
- ctrl0_i  in  CTRL_W  requester 0 ALU control code.
- src1_0_i  in  DATA_W  requester 0 operand 1.
- src2_0_i  in  DATA_W  requester 0 operand 2.
- req1_i  in  1  requester 1 request.
- ctrl1_i  in  CTRL_W  requester 1 ALU control code.
- src1_1_i  in  DATA_W  requester 1 operand 1.
- src2_1_i  in  DATA_W  requester 1 operand 2.
- ack0_o  out  1  one-cycle pulse: requester 0 accepted, operands latched.
- ack1_o  out  1  one-cycle pulse: requester 1 accepted.
- done0_o  out  1  one-cycle pulse: result for requester 0 valid.
- done1_o  out  1  one-cycle pulse: result for requester 1 valid.
- rslt_o  out  DATA_W  shared result bus; valid only with done0_o or done1_o.
- zero_o  out  1  captured ALU zero flag.
- err_o  out  1  set together with done for an ILLEGAL_CTRL request.
- busy_o  out  1  high in EXEC and RESP.
- alu_ctrl_o  out  CTRL_W  to ALU control input.
- alu_src1_o  out  DATA_W  to ALU operand 1.
- alu_src2_o  out  DATA_W  to ALU operand 2.
- alu_rslt_i  in  DATA_W  ALU result.
- alu_zero_i  in  1  ALU zero flag.

Behaviour:
- Reset (rst_i low at an edge): state=IDLE, last_gnt=1 (so requester 0 wins the first tie).
  - All outputs 0.
  - alu_ctrl_o=0, alu_src*_o=0.
  - Reset mid-EXEC or mid-RESP aborts the operation: no done and no err is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not last_gnt, then update last_gnt.
  - On grant:
    - latch ctrl/src1/src2 into operand registers;
    - pulse ack for one cycle, in the same cycle as the latch edge (ack is a registered output visible the next cycle);
    - record the owner.
  - Granted ctrl != ILLEGAL_CTRL: go to EXEC.
  - Granted ctrl == ILLEGAL_CTRL: go straight to RESP with err pending and rslt=0.
- EXEC (1 cycle)
  - alu_ctrl_o/alu_src*_o come directly from the operand registers.
  - At the end of the cycle, capture alu_rslt_i and alu_zero_i; go to RESP.
- RESP (1 cycle)
  - done_owner=1; rslt_o and zero_o hold the captured values; err_o=1 only for an illegal request.
  - Go to IDLE.
  - rslt_o, zero_o and err_o hold their value until the next RESP; they are meaningful only with done.
- Latency and throughput:
  - Request-to-done is 3 cycles: ack at T+1, done at T+3.
  - Throughput is one operation per 3 cycles.
  - The illegal path has a done at T+2.
- Request sampling:
  - Requests are sampled only in IDLE; a requester must hold req and operands stable until ack.
  - A req still high after done is treated as a new request.
- Outside EXEC, the ALU drive outputs hold the last operand registers, which are stable and never X.
- done0_o and done1_o are never high together; ack0_o and ack1_o are never high together.
- Zero flag: zero_o mirrors the ALU zero flag captured in EXEC (for example, SUB of equal operands gives zero_o=1). The block does not interpret the flag.
- Fairness: with both requesters continuously asserted, grants alternate 0,1,0,1.

Test Plan:
- Reset, then req0 alone with ctrl=0010, src1=5, src2=7 -> ack0 at T+1, alu_ctrl_o=0010 during EXEC, done0 at T+3 with rslt_o=12, zero_o=0, err_o=0.
- req1 alone with ctrl=0110, src1=src2=0x1234 -> done1 with rslt_o=0, zero_o=1.
- req0 and req1 held together for 4 operations -> grant order 0,1,0,1; each done pulse matches its owner's operands; acks and dones are never simultaneous.
- req0 with ctrl=1111 -> ack0, then done0 one cycle later with err_o=1, rslt_o=0; ALU drive registers loaded but no capture.
- Reset low during EXEC of a req1 operation -> no done1; all outputs 0 next cycle; after release, simultaneous requests grant req0 first.
- req0 held high continuously, operands changed after ack -> the first result uses the latched operands; the second operation uses the new operands and begins in the cycle after done0.
